read_controller: RTL

Dumps the coprocessor's 1024×8 block RAM over UART on host command. Watches received bytes for the three-byte sequence "rd" + 8'h0A, then reads addresses 0..1023 in order and hands each byte to the UART transmitter through a start/busy handshake. It is the read-back counterpart of the write path that loads the same RAM from the host.

---
 rtl/coproc_pkg.sv | 19 +
 rtl/cmd_detector.sv | 30 +++
 rtl/read_controller.sv | 125 ++++++++++++
 3 files changed

// File: rtl/coproc_pkg.sv
// Shared coprocessor definitions: read-controller state encoding and the
// host command / escape byte constants used by the read and write paths.
package coproc_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LATCH = 3'd2,
      SEND  = 3'd3,
      HOLD  = 3'd4,
      DRAIN = 3'd5
   } rd_state_t;

   // "rd\n" and "wa\n" as received over the UART, oldest byte in the MSBs
   localparam logic [23:0] CMD_READ  = {8'h72, 8'h64, 8'h0A};
   localparam logic [23:0] CMD_WRITE = {8'h77, 8'h61, 8'h0A};
   localparam logic [7:0]  ESC_BYTE  = 8'h1B;

endpackage

// File: rtl/cmd_detector.sv
// Three-byte command detector: shifts in received bytes while enabled and
// flags when the last three bytes equal PATTERN. Shared by read and write paths.
module cmd_detector
   import coproc_pkg::*;
#(
   parameter int                    DATA_W  = 8,
   parameter logic [3*DATA_W-1:0]   PATTERN = CMD_READ
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              shift_en,
   input  logic              clr,
   input  logic [DATA_W-1:0] byte_in,
   output logic              match
);

   logic [3*DATA_W-1:0] cmd;

   // History of the last three bytes; clear wins over shift so a match never lingers
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cmd <= '0;
      end else if (shift_en) begin
         cmd <= {cmd[2*DATA_W-1:0], byte_in};
      end
   end

   assign match = (cmd == PATTERN);

endmodule

// File: rtl/read_controller.sv
// RAM read-back controller: on "rd\n" from the host, streams RAM addresses
// 0..LAST_ADDR to the UART transmitter, one byte per start/busy handshake.
// Optional build macro READ_CTRL_ABORT_EN: an ESC byte received during a
// transfer ends it after the byte currently in flight, with no done pulse.
module read_controller
   import coproc_pkg::*;
#(
   parameter int ADDR_W    = 10,
   parameter int LAST_ADDR = 1023
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        byte_received,
   input  logic              rx_data_ready,
   output logic              en,
   output logic [ADDR_W-1:0] addr,
   input  logic [7:0]        dout,
   output logic [7:0]        tx_data,
   output logic              tx_start,
   input  logic              tx_busy,
   output logic [2:0]        status,
   output logic              done
);

   rd_state_t state;
   logic      cmd_match;
   logic      cmd_shift;
   logic      cmd_clr;
   logic      at_last;
   logic      abort_now;
   logic      drain_exit;

   // Bytes only count toward a command while idle; a match is consumed on exit
   assign cmd_shift  = (state == IDLE) && rx_data_ready;
   assign cmd_clr    = (state == IDLE) && cmd_match;
   assign at_last    = (addr == ADDR_W'(LAST_ADDR));
   assign drain_exit = (state == DRAIN) && !tx_busy;

   cmd_detector #(
      .DATA_W  (8),
      .PATTERN (CMD_READ)
   ) u_cmd_detector (
      .clk      (clk),
      .rst      (rst),
      .shift_en (cmd_shift),
      .clr      (cmd_clr),
      .byte_in  (byte_received),
      .match    (cmd_match)
   );

`ifdef READ_CTRL_ABORT_EN
   logic abort_flag;
   logic esc_seen;

   assign esc_seen  = rx_data_ready && (byte_received == ESC_BYTE) && (state != IDLE);
   // An ESC arriving on the exit cycle itself still aborts
   assign abort_now = abort_flag || esc_seen;

   // Sticky abort request, consumed at the next byte boundary
   always_ff @(posedge clk) begin
      if (rst || drain_exit) begin
         abort_flag <= 1'b0;
      end else if (esc_seen) begin
         abort_flag <= 1'b1;
      end
   end
`else
   assign abort_now = 1'b0;
`endif

   // Transfer sequencer: fetch, latch, hand off, then wait out the transmitter
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         addr    <= '0;
         tx_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_match) begin
                  state <= FETCH;
                  addr  <= '0;
               end
            end
            FETCH: state <= LATCH;
            LATCH: begin
               tx_data <= dout;
               state   <= SEND;
            end
            SEND: begin
               if (!tx_busy) state <= HOLD;
            end
            HOLD: state <= DRAIN;
            DRAIN: begin
               if (!tx_busy) begin
                  if (at_last || abort_now) begin
                     state <= IDLE;
                     addr  <= '0;
                  end else begin
                     state <= FETCH;
                     addr  <= addr + ADDR_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Strobes decoded directly from the current state
   always_comb begin
      en       = 1'b0;
      tx_start = 1'b0;
      done     = 1'b0;
      case (state)
         FETCH: en       = 1'b1;
         SEND:  tx_start = !tx_busy;
         DRAIN: done     = drain_exit && at_last && !abort_now;
         default: ;
      endcase
   end

   assign status = state;

endmodule
